// File: rtl/enemy_motion_ctrl.sv
// enemy_motion_ctrl: decodes the AI command word and runs the enemy motion FSM.
// Position, facing and state advance once per frame_tick.
module enemy_motion_ctrl #(
  parameter int X_MIN           = 16,
  parameter int X_MAX           = 608,
  parameter int Y_MIN           = 64,
  parameter int GROUND_Y        = 400,
  parameter int X_INIT          = 480,
  parameter int JUMP_V          = 12,
  parameter int GRAVITY         = 1,
  parameter int ATTACK_FRAMES   = 16,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        frame_tick,
  input  logic [15:0] cmd_word,
  output logic [9:0]  enemy_x,
  output logic [9:0]  enemy_y,
  output logic [15:0] enemy_loc,
  output logic        facing,
  output logic        attacking,
  output logic        busy,
  output logic        ack_tag
);
  localparam logic signed [10:0] XMN = 11'(X_MIN);
  localparam logic signed [10:0] XMX = 11'(X_MAX);
  localparam logic signed [10:0] YMN = 11'(Y_MIN);
  localparam logic signed [10:0] GND = 11'(GROUND_Y);
  localparam logic signed [10:0] VJ  = 11'(JUMP_V);
  localparam logic signed [10:0] GR  = 11'(GRAVITY);
  typedef enum logic [2:0] {IDLE, MOVE, JUMP, ATTACK, COOLDOWN} state_t;
  state_t state;
  logic [2:0] op;
  logic [1:0] dir;
  logic [2:0] step;
  logic [7:0] cnt;
  logic signed [10:0] vy, stp, dx, dy, xm, ym, yn, xc, yc;
  assign op        = cmd_word[14:12];
  assign enemy_loc = {enemy_x[9:2], enemy_y[9:2]};
  assign attacking = (state == ATTACK);
  assign busy      = (state != IDLE);
  // A jump with speed 0 (step 1) is purely vertical.
  always_comb begin
    stp = $signed({8'd0, step});
    dx  = ((state == MOVE && !dir[1]) || (state == JUMP && step != 3'd1)) ? (dir[0] ? stp : -stp) : '0;
    dy  = (state == MOVE && dir[1]) ? (dir[0] ? stp : -stp) : '0;
    xm  = $signed({1'b0, enemy_x}) + dx;
    ym  = $signed({1'b0, enemy_y}) + dy;
    yn  = $signed({1'b0, enemy_y}) + vy;
    xc  = xm < XMN ? XMN : (xm > XMX ? XMX : xm);
    yc  = ym < YMN ? YMN : (ym > GND ? GND : ym);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      enemy_x <= 10'(X_INIT);
      enemy_y <= 10'(GROUND_Y);
      vy      <= '0;
      facing  <= 1'b0;
      ack_tag <= 1'b0;
      cnt     <= '0;
      dir     <= '0;
      step    <= 3'd1;
    end else if (state == IDLE) begin
      if (cmd_word[15] != ack_tag) begin
        ack_tag <= cmd_word[15];
        dir     <= cmd_word[11:10];
        step    <= {1'b0, cmd_word[9:8]} + 3'd1;
        if ((op == 3'd1 || op == 3'd2) && !cmd_word[11]) facing <= cmd_word[10];
        if (op == 3'd1) begin
          state <= MOVE;
          cnt   <= (cmd_word[7:0] == 8'd0) ? 8'd1 : cmd_word[7:0];
        end else if (op == 3'd2) begin
          state <= JUMP;
          vy    <= -VJ;
        end else if (op == 3'd3) begin
          state <= ATTACK;
          cnt   <= 8'(ATTACK_FRAMES);
        end
      end
    end else if (frame_tick) begin
      case (state)
        MOVE: begin
          enemy_x <= xc[9:0];
          enemy_y <= yc[9:0];
          cnt     <= cnt - 8'd1;
          if (cnt == 8'd1) state <= IDLE;
        end
        JUMP: begin
          enemy_x <= xc[9:0];
          if (vy > 0 && yn >= GND) begin
            enemy_y <= GND[9:0];
            vy      <= '0;
            state   <= IDLE;
          end else begin
            enemy_y <= (yn < YMN) ? YMN[9:0] : yn[9:0];
            vy      <= vy + GR;
          end
        end
        ATTACK: begin
          cnt <= (cnt == 8'd1) ? 8'(COOLDOWN_FRAMES) : cnt - 8'd1;
          if (cnt == 8'd1) state <= COOLDOWN;
        end
        default: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_enemy_motion_ctrl.sv
// tb_enemy_motion_ctrl: trajectory-plan reference model, directed scenarios, then random commands.
// Each accepted command is expanded into a queue of per-tick outcomes that ticks then consume.
module tb_enemy_motion_ctrl;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        frame_tick = 1'b0;
  logic [15:0] cmd_word = 16'h0000;
  logic [9:0]  enemy_x, enemy_y;
  logic [15:0] enemy_loc;
  logic        facing, attacking, busy, ack_tag;

  enemy_motion_ctrl dut (
    .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .cmd_word(cmd_word),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_loc(enemy_loc), .facing(facing),
    .attacking(attacking), .busy(busy), .ack_tag(ack_tag)
  );

  always #5 CLK = ~CLK;

  typedef struct {int x; int y; bit att;} ent_t;
  ent_t plan[$];
  int   mx = 480, my = 400;
  bit   mf = 1'b0, mtag = 1'b0;
  int   vec = 0, errs = 0;
  bit   chk_en = 1'b0;

  function automatic int clampi(input int v, input int lo, input int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic accept(input logic [15:0] c);
    int op, stp, dur, px, py, vy, d;
    mtag = c[15];
    op   = int'(c[14:12]);
    stp  = int'(c[9:8]) + 1;
    dur  = int'(c[7:0]);
    d    = c[10] ? stp : -stp;
    px   = mx;
    py   = my;
    if ((op == 1 || op == 2) && !c[11]) mf = c[10];
    if (op == 1) begin
      repeat (dur == 0 ? 1 : dur) begin
        if (!c[11]) px = clampi(px + d, 16, 608);
        else py = clampi(py + d, 64, 400);
        plan.push_back('{px, py, 1'b0});
      end
    end else if (op == 2) begin
      vy = -12;
      for (int k = 0; k < 2000; k++) begin
        if (c[9:8] != 2'd0) px = clampi(px + d, 16, 608);
        if (vy > 0 && py + vy >= 400) begin
          plan.push_back('{px, 400, 1'b0});
          break;
        end
        py = (py + vy < 64) ? 64 : py + vy;
        vy++;
        plan.push_back('{px, py, 1'b0});
      end
    end else if (op == 3) begin
      repeat (16) plan.push_back('{px, py, 1'b1});
      repeat (8) plan.push_back('{px, py, 1'b0});
    end
  endtask

  always @(posedge CLK) begin
    if (RESET) begin
      mx = 480; my = 400; mf = 1'b0; mtag = 1'b0;
      plan.delete();
    end else if (plan.size() == 0) begin
      if (cmd_word[15] != mtag) accept(cmd_word);
    end else if (frame_tick) begin
      mx = plan[0].x;
      my = plan[0].y;
      void'(plan.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("x", int'(enemy_x), mx);
      chk("y", int'(enemy_y), my);
      chk("loc", int'(enemy_loc), ((mx >> 2) << 8) | (my >> 2));
      chk("facing", int'(facing), int'(mf));
      chk("attacking", int'(attacking), (plan.size() != 0 && plan[0].att) ? 1 : 0);
      chk("busy", int'(busy), plan.size() != 0 ? 1 : 0);
      chk("ack_tag", int'(ack_tag), int'(mtag));
    end
  end

  task automatic cyc(input bit t);
    frame_tick = t;
    @(negedge CLK);
    frame_tick = 1'b0;
  endtask

  task automatic send(input logic [15:0] c);
    cmd_word = c;
    cyc(1'b0);
  endtask

  initial begin
    int t, miny, mint, att_n;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("t1_loc", int'(enemy_loc), 16'h7864);
    chk("t1_x", int'(enemy_x), 480);
    chk("t1_busy", int'(busy), 0);
    chk("t1_ack", int'(ack_tag), 0);

    send(16'h9503);
    chk("t2_ack", int'(ack_tag), 1);
    repeat (3) cyc(1'b1);
    chk("t2_x", int'(enemy_x), 486);
    chk("t2_facing", int'(facing), 1);
    chk("t2_busy", int'(busy), 0);

    send(16'h171E);
    for (int i = 0; i < 30; i++) cyc(1'b1);
    send(16'h9401);
    cyc(1'b1);
    chk("t3_x607", int'(enemy_x), 607);
    send(16'h1702);
    cyc(1'b1);
    chk("t3_x_tick1", int'(enemy_x), 608);
    cyc(1'b1);
    chk("t3_x_tick2", int'(enemy_x), 608);
    chk("t3_y", int'(enemy_y), 400);
    chk("t3_busy", int'(busy), 0);

    send(16'h8000);
    chk("nop_busy", int'(busy), 0);
    send(16'h2000);
    t = 0; miny = 1000; mint = 0;
    while (busy && t < 60) begin
      cyc(1'b1);
      t++;
      if (t == 1) chk("t4_y_tick1", int'(enemy_y), 388);
      if (int'(enemy_y) < miny) begin
        miny = int'(enemy_y);
        mint = t;
      end
      if (t == 13) chk("t4_y_tick13", int'(enemy_y), 322);
    end
    chk("t4_min_y", miny, 322);
    chk("t4_min_tick", mint, 12);
    chk("t4_land_tick", t, 25);
    chk("t4_land_y", int'(enemy_y), 400);

    send(16'hB000);
    t = 0; att_n = 0;
    while (busy && t < 100) begin
      if (attacking) att_n++;
      cyc(1'b1);
      t++;
    end
    chk("t5_attack_ticks", att_n, 16);
    chk("t5_busy_ticks", t, 24);

    send(16'h3000);
    repeat (5) cyc(1'b1);
    send(16'hA000);
    chk("t6_held_ack", int'(ack_tag), 0);
    t = 0;
    while (busy && t < 100) begin
      cyc(1'b1);
      t++;
    end
    chk("t6_idle_ack", int'(ack_tag), 0);
    cyc(1'b0);
    chk("t6_accept_ack", int'(ack_tag), 1);
    chk("t6_accept_busy", int'(busy), 1);
    repeat (3) cyc(1'b1);
    RESET = 1'b1;
    cmd_word = 16'h0000;
    cyc(1'b0);
    chk("t6_reset_y", int'(enemy_y), 400);
    chk("t6_reset_busy", int'(busy), 0);
    RESET = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)
        cmd_word = {~cmd_word[15], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 8'($urandom_range(0, 12))};
      RESET = ($urandom_range(0, 499) == 0);
      cyc(1'($urandom_range(0, 1)));
    end
    RESET = 1'b0;
    cyc(1'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
